// File: rtl/chase_pkg.sv
// Shared types, constants and the speed saturation helper for the chase controller.
package chase_pkg;

  localparam int unsigned SPEED_W = 9;

  // FSM state encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StCalc   = 3'd2;
  localparam logic [2:0] StTarget = 3'd3;
  localparam logic [2:0] StApply  = 3'd4;

  // Horizontal image centre for the half-size and full-size frame
  localparam logic signed [10:0] CentreHalf = 11'sd160;
  localparam logic signed [10:0] CentreFull = 11'sd320;

  // Clamp a signed 12-bit demand to +/-max_v and narrow it to a wheel speed.
  function automatic logic signed [SPEED_W-1:0] sat_speed(input logic signed [11:0] v,
                                                           input logic signed [11:0] max_v);
    logic signed [11:0] r;
    if (v > max_v) begin
      r = max_v;
    end else if (v < -max_v) begin
      r = -max_v;
    end else begin
      r = v;
    end
    return r[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/chase_ctrl_slew_limiter.sv
// Per-wheel speed register that steps toward a target by at most SLEW per update.
module slew_limiter
  import chase_pkg::*;
#(
  parameter int SLEW = 16
) (
  input  logic                      clk_65mhz,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      zero,
  input  logic signed [SPEED_W-1:0] tgt,
  output logic signed [SPEED_W-1:0] speed
);

  localparam int unsigned DW = SPEED_W + 1;
  localparam logic signed [DW-1:0]      SlewD = DW'(SLEW);
  localparam logic signed [SPEED_W-1:0] SlewS = SPEED_W'(SLEW);

  logic signed [SPEED_W-1:0] speed_q, speed_d;
  logic signed [DW-1:0]      diff;

  // Next speed: forced zero wins, otherwise a rate-limited step when enabled
  always_comb begin
    diff    = $signed({tgt[SPEED_W-1], tgt}) - $signed({speed_q[SPEED_W-1], speed_q});
    speed_d = speed_q;
    if (zero) begin
      speed_d = '0;
    end else if (en) begin
      if (diff > SlewD) begin
        speed_d = speed_q + SlewS;
      end else if (diff < -SlewD) begin
        speed_d = speed_q - SlewS;
      end else begin
        speed_d = tgt;
      end
    end
  end

  // Speed register
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= '0;
    end else begin
      speed_q <= speed_d;
    end
  end

  assign speed = speed_q;

endmodule

// File: rtl/chase_ctrl.sv
// Frame-rate motion scheduler: per frame, snapshot the tracked blob, derive forward/turn
// demands, and slew both wheel speeds toward the saturated targets.
module chase_ctrl
  import chase_pkg::*;
#(
  parameter int MAX_SPEED   = 200,
  parameter int SLEW        = 16,
  parameter int KF_SHIFT    = 2,
  parameter int TURN_SHIFT  = 1,
  parameter int DEADBAND    = 8,
  parameter int LOST_FRAMES = 15
) (
  input  logic                      clk_65mhz,
  input  logic                      reset_n,
  input  logic                      vsync,
  input  logic                      track,
  input  logic                      move,
  input  logic                      sw2,
  input  logic [8:0]                cur_pos_x,
  input  logic [8:0]                cur_pos_y,
  input  logic [6:0]                cur_rad,
  input  logic [6:0]                goal_rad,
  output logic signed [SPEED_W-1:0] speed1,
  output logic signed [SPEED_W-1:0] speed2,
  output logic                      cmd_valid,
  output logic                      lost,
  output logic [2:0]                state
);

  localparam int unsigned LcW = $clog2(LOST_FRAMES + 1);
  localparam logic [LcW-1:0]     LostMax = LcW'(LOST_FRAMES);
  localparam logic signed [11:0] MaxS    = 12'(MAX_SPEED);
  localparam logic signed [10:0] DbPos   = 11'(DEADBAND);
  localparam logic signed [10:0] DbNeg   = -DbPos;

  logic [2:0]                state_q, state_d;
  logic                      vsync_q;
  logic                      frame;
  logic [8:0]                pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [6:0]                rad_q, rad_d, goal_q, goal_d;
  logic                      sw2_q, sw2_d, track_q, track_d;
  logic signed [10:0]        err_x_q, err_x_d;
  logic signed [7:0]         err_r_q, err_r_d;
  logic [LcW-1:0]            lost_cnt_q, lost_cnt_d;
  logic signed [SPEED_W-1:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      lost_q, lost_d;
  logic signed [11:0]        forward, turn, sum1, sum2;
  logic                      slew_en, slew_zero;
  logic                      unused_pos_y;

  assign frame = vsync & ~vsync_q;

  // Y position is captured for future use but not yet part of the control law
  assign unused_pos_y = ^pos_y_q;

  // Demand arithmetic, all in signed 12 bits so nothing can wrap before saturation
  always_comb begin
    forward = $signed({{4{err_r_q[7]}}, err_r_q}) <<< KF_SHIFT;
    if (err_x_q >= DbNeg && err_x_q <= DbPos) begin
      turn = 12'sd0;
    end else begin
      turn = $signed({err_x_q[10], err_x_q}) >>> TURN_SHIFT;
    end
    sum1 = forward + turn;
    sum2 = forward - turn;
  end

  // FSM and pipeline next-state; move low overrides everything, including a frame edge
  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    rad_d       = rad_q;
    goal_d      = goal_q;
    sw2_d       = sw2_q;
    track_d     = track_q;
    err_x_d     = err_x_q;
    err_r_d     = err_r_q;
    lost_cnt_d  = lost_cnt_q;
    tgt1_d      = tgt1_q;
    tgt2_d      = tgt2_q;
    cmd_valid_d = 1'b0;
    lost_d      = lost_q;
    slew_en     = 1'b0;
    slew_zero   = 1'b0;
    if (!move) begin
      state_d   = StIdle;
      slew_zero = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          slew_zero = 1'b1;
          state_d   = StWait;
        end
        StWait: begin
          if (frame) begin
            pos_x_d = cur_pos_x;
            pos_y_d = cur_pos_y;
            rad_d   = cur_rad;
            goal_d  = goal_rad;
            sw2_d   = sw2;
            track_d = track;
            state_d = StCalc;
          end
        end
        StCalc: begin
          err_x_d = $signed({2'b00, pos_x_q}) - (sw2_q ? CentreFull : CentreHalf);
          err_r_d = $signed({1'b0, goal_q}) - $signed({1'b0, rad_q});
          if (rad_q == 7'd0 && track_q) begin
            if (lost_cnt_q != LostMax) begin
              lost_cnt_d = lost_cnt_q + LcW'(1);
            end
          end else if (rad_q != 7'd0) begin
            lost_cnt_d = '0;
          end
          state_d = StTarget;
        end
        StTarget: begin
          if (!track_q || lost_cnt_q == LostMax) begin
            tgt1_d = '0;
            tgt2_d = '0;
          end else begin
            tgt1_d = sat_speed(sum1, MaxS);
            tgt2_d = sat_speed(sum2, MaxS);
          end
          state_d = StApply;
        end
        StApply: begin
          slew_en     = 1'b1;
          cmd_valid_d = 1'b1;
          lost_d      = (lost_cnt_q == LostMax);
          state_d     = StWait;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, snapshot and pipeline registers
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      rad_q       <= '0;
      goal_q      <= '0;
      sw2_q       <= 1'b0;
      track_q     <= 1'b0;
      err_x_q     <= '0;
      err_r_q     <= '0;
      lost_cnt_q  <= '0;
      tgt1_q      <= '0;
      tgt2_q      <= '0;
      cmd_valid_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      rad_q       <= rad_d;
      goal_q      <= goal_d;
      sw2_q       <= sw2_d;
      track_q     <= track_d;
      err_x_q     <= err_x_d;
      err_r_q     <= err_r_d;
      lost_cnt_q  <= lost_cnt_d;
      tgt1_q      <= tgt1_d;
      tgt2_q      <= tgt2_d;
      cmd_valid_q <= cmd_valid_d;
      lost_q      <= lost_d;
    end
  end

  slew_limiter #(
    .SLEW(SLEW)
  ) u_slew1 (
    .clk_65mhz(clk_65mhz),
    .reset_n  (reset_n),
    .en       (slew_en),
    .zero     (slew_zero),
    .tgt      (tgt1_q),
    .speed    (speed1)
  );

  slew_limiter #(
    .SLEW(SLEW)
  ) u_slew2 (
    .clk_65mhz(clk_65mhz),
    .reset_n  (reset_n),
    .en       (slew_en),
    .zero     (slew_zero),
    .tgt      (tgt2_q),
    .speed    (speed2)
  );

  assign cmd_valid = cmd_valid_q;
  assign lost      = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_chase_ctrl.sv
// Directed plus randomized bench for chase_ctrl against a per-frame arithmetic model.
module tb_chase_ctrl;

  localparam int MaxSpeed = 200;
  localparam int Slew     = 16;
  localparam int LostN    = 15;

  logic              clk_65mhz = 1'b0;
  logic              reset_n;
  logic              vsync, track, move, sw2;
  logic [8:0]        cur_pos_x, cur_pos_y;
  logic [6:0]        cur_rad, goal_rad;
  logic signed [8:0] speed1, speed2;
  logic              cmd_valid, lost;
  logic [2:0]        state;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_spd1 = 0;
  int m_spd2 = 0;
  int m_cnt  = 0;
  bit m_lost = 1'b0;

  chase_ctrl dut (
    .clk_65mhz(clk_65mhz),
    .reset_n  (reset_n),
    .vsync    (vsync),
    .track    (track),
    .move     (move),
    .sw2      (sw2),
    .cur_pos_x(cur_pos_x),
    .cur_pos_y(cur_pos_y),
    .cur_rad  (cur_rad),
    .goal_rad (goal_rad),
    .speed1   (speed1),
    .speed2   (speed2),
    .cmd_valid(cmd_valid),
    .lost     (lost),
    .state    (state)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > MaxSpeed) return MaxSpeed;
    if (v < -MaxSpeed) return -MaxSpeed;
    return v;
  endfunction

  function automatic int step_to(input int s, input int t);
    if (t > s + Slew) return s + Slew;
    if (t < s - Slew) return s - Slew;
    return t;
  endfunction

  // One frame of the control law, straight from the rules
  task automatic model_frame(input int x, input int rad, input int goal, input bit sw,
                             input bit trk);
    int err_x, err_r, fwd, trn, t1, t2;
    err_x = x - (sw ? 320 : 160);
    err_r = goal - rad;
    if (rad == 0 && trk) begin
      if (m_cnt < LostN) m_cnt++;
    end else if (rad != 0) begin
      m_cnt = 0;
    end
    if (!trk || m_cnt == LostN) begin
      t1 = 0;
      t2 = 0;
    end else begin
      fwd = err_r * 4;
      if (err_x >= -8 && err_x <= 8) trn = 0;
      else if (err_x >= 0) trn = err_x / 2;
      else trn = -((1 - err_x) / 2);  // floor of err_x/2 for negatives
      t1 = clamp(fwd + trn);
      t2 = clamp(fwd - trn);
    end
    m_spd1 = step_to(m_spd1, t1);
    m_spd2 = step_to(m_spd2, t2);
    m_lost = (m_cnt == LostN);
  endtask

  // Raise vsync for one clock, then check the update lands exactly in cycle N+4
  task automatic run_frame(input string tag, input int x, input int rad, input int goal,
                           input bit sw, input bit trk);
    @(posedge clk_65mhz); #1;
    cur_pos_x = 9'(x);
    cur_pos_y = 9'($urandom_range(0, 511));
    cur_rad   = 7'(rad);
    goal_rad  = 7'(goal);
    sw2       = sw;
    track     = trk;
    vsync     = 1'b1;
    model_frame(x, rad, goal, sw, trk);
    @(posedge clk_65mhz); #1;
    vsync = 1'b0;
    repeat (2) @(posedge clk_65mhz);
    #1;
    check({tag, ".cv_early"}, cmd_valid, 0);
    @(posedge clk_65mhz); #1;
    check({tag, ".cv"}, cmd_valid, 1);
    check({tag, ".spd1"}, speed1, m_spd1);
    check({tag, ".spd2"}, speed2, m_spd2);
    check({tag, ".lost"}, lost, m_lost);
    @(posedge clk_65mhz); #1;
    check({tag, ".cv_late"}, cmd_valid, 0);
  endtask

  // Drop move on the same cycle as a vsync rise
  task automatic drop_move(input string tag);
    int pulses;
    @(posedge clk_65mhz); #1;
    move  = 1'b0;
    vsync = 1'b1;
    @(posedge clk_65mhz); #1;
    vsync  = 1'b0;
    m_spd1 = 0;
    m_spd2 = 0;
    check({tag, ".spd1"}, speed1, 0);
    check({tag, ".spd2"}, speed2, 0);
    check({tag, ".state"}, state, 0);
    check({tag, ".lost"}, lost, m_lost);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid) pulses++;
      @(posedge clk_65mhz); #1;
    end
    check({tag, ".no_cv"}, pulses, 0);
    move = 1'b1;
    @(posedge clk_65mhz); #1;
    check({tag, ".rewait"}, state, 1);
  endtask

  initial begin
    int pulses;
    int x, rad, goal;
    bit sw, trk;
    reset_n   = 1'b0;
    vsync     = 1'b0;
    track     = 1'b0;
    move      = 1'b0;
    sw2       = 1'b0;
    cur_pos_x = '0;
    cur_pos_y = '0;
    cur_rad   = '0;
    goal_rad  = '0;
    repeat (3) @(posedge clk_65mhz);
    #1;
    check("rst.spd1", speed1, 0);
    check("rst.spd2", speed2, 0);
    check("rst.cv", cmd_valid, 0);
    check("rst.lost", lost, 0);
    check("rst.state", state, 0);
    reset_n = 1'b1;
    @(posedge clk_65mhz); #1;
    check("idle.hold", state, 0);
    move = 1'b1;
    @(posedge clk_65mhz); #1;
    check("idle.to_wait", state, 1);

    // 1: pure forward
    run_frame("fwd1", 160, 20, 30, 1'b0, 1'b1);
    check("fwd1.val", speed1, 16);
    run_frame("fwd2", 160, 20, 30, 1'b0, 1'b1);
    check("fwd2.val", speed2, 32);
    run_frame("fwd3", 160, 20, 30, 1'b0, 1'b1);
    check("fwd3.val", speed1, 40);

    // 2: pure turn, then inside the deadband
    drop_move("drop_a");
    run_frame("turn1", 200, 25, 25, 1'b0, 1'b1);
    check("turn1.s2", speed2, -16);
    run_frame("turn2", 200, 25, 25, 1'b0, 1'b1);
    check("turn2.s1", speed1, 20);
    run_frame("db1", 166, 25, 25, 1'b0, 1'b1);
    run_frame("db2", 166, 25, 25, 1'b0, 1'b1);
    check("db2.s1", speed1, 0);

    // 3: saturation both ways
    for (int i = 0; i < 15; i++) run_frame("sat_pos", 160, 1, 127, 1'b0, 1'b1);
    check("sat_pos.s1", speed1, 200);
    check("sat_pos.s2", speed2, 200);
    for (int i = 0; i < 27; i++) run_frame("sat_neg", 160, 127, 0, 1'b0, 1'b1);
    check("sat_neg.s1", speed1, -200);

    // 4: lost target from speed 40, with the last computed target also 40
    drop_move("drop_b");
    for (int i = 0; i < 3; i++) run_frame("pre_lost", 160, 20, 30, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) run_frame("blobless", 160, 0, 10, 1'b0, 1'b1);
    check("lost14.flag", lost, 0);
    check("lost14.s1", speed1, 40);
    run_frame("lost15", 160, 0, 10, 1'b0, 1'b1);
    check("lost15.flag", lost, 1);
    check("lost15.s1", speed1, 24);
    run_frame("lost16", 160, 0, 10, 1'b0, 1'b1);
    check("lost16.s1", speed1, 8);
    run_frame("lost17", 160, 0, 10, 1'b0, 1'b1);
    check("lost17.s1", speed1, 0);
    run_frame("found", 160, 20, 10, 1'b0, 1'b1);
    check("found.flag", lost, 0);

    // 5: move drop at speed 120
    for (int i = 0; i < 10; i++) run_frame("to120", 160, 20, 50, 1'b0, 1'b1);
    check("to120.s1", speed1, 120);
    drop_move("drop_c");

    // 6: async reset while in CALC
    run_frame("pre_rst", 160, 20, 30, 1'b0, 1'b1);
    @(posedge clk_65mhz); #1;
    vsync = 1'b1;
    @(posedge clk_65mhz); #1;
    vsync = 1'b0;
    check("mid.calc", state, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.s1", speed1, 0);
    check("arst.s2", speed2, 0);
    check("arst.state", state, 0);
    check("arst.cv", cmd_valid, 0);
    m_spd1 = 0;
    m_spd2 = 0;
    m_cnt  = 0;
    m_lost = 1'b0;
    @(posedge clk_65mhz); #1;
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_65mhz); #1;
      if (cmd_valid) pulses++;
    end
    check("arst.no_cv", pulses, 0);
    run_frame("post_rst", 160, 20, 30, 1'b0, 1'b1);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      x    = int'($urandom_range(0, 511));
      rad  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
      goal = int'($urandom_range(0, 127));
      sw   = 1'($urandom_range(0, 1));
      trk  = ($urandom_range(0, 7) != 0);
      run_frame("rand", x, rad, goal, sw, trk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chase_ctrl.md
Name: chase_ctrl

Overview:
- Frame-rate motion scheduler for the chasebot.
- Once a frame completes, it samples the tracked blob position and radius from the tracker and compares them against the goal radius latched during initialization.
- It computes forward and turn demands and drives the two signed wheel speeds `speed1` and `speed2`, which also feed the on-screen speed bar.
- It owns the lost-target timeout and slew limiting, and sits between the initialize FSM (`track`/`move`) and the motor PWM block.

Parameters:
- MAX_SPEED, 200, saturation magnitude for `speed1`/`speed2`.
- SLEW, 16, maximum per-frame change of each speed.
- KF_SHIFT, 2, forward gain: `forward = err_r <<< KF_SHIFT`.
- TURN_SHIFT, 1, turn gain: `turn = err_x >>> TURN_SHIFT`.
- DEADBAND, 8, `|err_x| <= DEADBAND` forces `turn = 0`.
- LOST_FRAMES, 15, number of consecutive blob-less frames before `lost` asserts.

Ports:
- clk_65mhz  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  video vsync, synchronous to clk_65mhz, active high at frame end
- track  in  1  tracker enabled (from initialize)
- move  in  1  motion enabled (from initialize)
- sw2  in  1  full-size frame select: centre x = 320 if 1, 160 if 0
- cur_pos_x  in  9  blob centre x
- cur_pos_y  in  9  blob centre y (sampled, reserved)
- cur_rad  in  7  blob radius; 0 means no blob
- goal_rad  in  7  target radius
- speed1  out  9 signed  left wheel speed
- speed2  out  9 signed  right wheel speed
- cmd_valid  out  1  one-clock pulse when speeds update
- lost  out  1  target-lost flag
- state  out  3  FSM state (debug)

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- All outputs go to 0 and the FSM to IDLE; the snapshot registers, `lost_cnt` and `vsync_d` are cleared.

Frame edge:
- `vsync_d` registers `vsync`.
- `frame = vsync & ~vsync_d`, evaluated in cycle N.

States:
- IDLE (0)
  - `speed1`/`speed2` are held at 0.
  - Go to WAIT when `move == 1`.
- WAIT (1)
  - On `frame`: snapshot `cur_pos_x`, `cur_pos_y`, `cur_rad`, `goal_rad`, `sw2` and `track`, then go to CALC.
- CALC (2)
  - Register `err_x = x - centre` (signed 11).
  - Register `err_r = goal_rad - cur_rad` (signed 8).
  - Update the blob-less counter:
    - If `cur_rad == 0` and `track == 1`: `lost_cnt` increments, saturating at LOST_FRAMES.
    - Otherwise, if `cur_rad != 0`: `lost_cnt` clears.
  - Go to TARGET.
- TARGET (3)
  - If `track == 0` or `lost_cnt == LOST_FRAMES`: `tgt1 = tgt2 = 0`.
  - Otherwise: `tgt1 = sat(forward + turn)` and `tgt2 = sat(forward - turn)`.
    - Sums are signed 12 bit.
    - `sat` clamps to ±MAX_SPEED.
  - Go to APPLY.
- APPLY (4)
  - Each speed steps toward its target by `min(|tgt - speed|, SLEW)`.
  - `cmd_valid` pulses for this clock.
  - `lost` is registered as `lost_cnt == LOST_FRAMES`.
  - Go to WAIT.

Latency:
- Speeds and `cmd_valid` update at the clock edge ending cycle N+3, so they are visible in cycle N+4.
- Exactly one update occurs per frame edge.

Boundaries:
- `move` falling in any state:
  - Next state is IDLE; speeds go to 0 on the next edge with no slew.
  - `lost_cnt` is preserved; `lost` is unchanged.
  - `move` low takes priority over a simultaneous `frame`.
- `frame` arriving in CALC/TARGET/APPLY is ignored; a pipeline pass never overlaps another.
- `lost` clears in the APPLY of the first frame that has `cur_rad != 0`.
- `err_r` saturation: with `err_r = 127` and KF_SHIFT = 2, `forward = 508`, which clamps to MAX_SPEED. No wrap is permitted anywhere.
- Reset assertion mid-pipeline aborts immediately to the reset values.

Decomposition:
- `chase_pkg` holds:
  - the state enum (IDLE, WAIT, CALC, TARGET, APPLY);
  - `SPEED_W = 9`;
  - centre constants 160 and 320;
  - a `sat_speed` function (signed 12 in, signed 9 out, clamping to ±MAX_SPEED).
- Sub-module `slew_limiter`, instantiated twice:
  - inputs: `clk_65mhz`, `reset_n`, `en`, `zero`, `tgt`;
  - output: registered `speed`.

Test Plan:
1. Pure forward.
   - Stimulus: `sw2 = 0`, `move = track = 1`, x = 160, `cur_rad = 20`, `goal_rad = 30`; 3 frames.
   - Required: `speed1 = speed2 = 16`, 32, 40; `cmd_valid` pulses 4 clocks after each vsync rise.
2. Pure turn.
   - Stimulus: x = 200, `cur_rad = goal_rad = 25`.
   - Required: `speed1/speed2` = +16/-16, then +20/-20.
   - Also drive x = 166: `err_x = 6`, inside the deadband, so targets are 0/0.
3. Saturation.
   - Stimulus: `goal_rad = 127`, `cur_rad = 1`, x = 160.
   - Required: speeds ramp by 16 per frame and hold at exactly 200, never wrapping negative.
   - Also drive `goal_rad = 0`, `cur_rad = 127`: speeds reach -200.
4. Lost target.
   - Stimulus: from `speed = 40`, `cur_rad = 0` for 15 frames.
   - Required: speeds move toward the last computed `sat()` target for 14 frames; `lost` rises in the APPLY of frame 15; speeds then ramp 40→24→8→0.
   - Then drive `cur_rad = 20`: `lost` clears next frame.
5. Move drop.
   - Stimulus: `speed = 120`; deassert `move` in the same cycle as a vsync rise.
   - Required: speeds are 0 the next clock, state = IDLE, no `cmd_valid` pulse.
6. Async reset.
   - Stimulus: assert `reset_n = 0` mid-CALC, with no clock edge.
   - Required: outputs are 0 and `state = 0` immediately.
   - After release, the first update occurs only after a fresh vsync rise.
